// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The FSM state encoding lives here so decode-side tooling can reuse it.
package instruction_fetch_pkg;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int PC_WIDTH          = 32;

  typedef enum logic [2:0] {
    FETCH_STATE_REQUEST = 3'd0,
    FETCH_STATE_WAIT    = 3'd1,
    FETCH_STATE_HOLD    = 3'd2,
    FETCH_STATE_DISCARD = 3'd3,
    FETCH_STATE_ERROR   = 3'd4
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [PC_WIDTH-1:0] address);
    return address[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding memory read FSM, PC register and a
// registered {instruction, pc} slot handed to decode over valid/ready.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         redirect_valid,
  input  logic [PC_WIDTH-1:0]          redirect_target,
  output logic                         memory_request,
  output logic [PC_WIDTH-1:0]          memory_address,
  input  logic                         memory_ready,
  input  logic                         memory_response_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] memory_response_data,
  output logic                         instruction_valid,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]          instruction_pc,
  input  logic                         decode_ready,
  output logic                         fetch_error
);

  fetch_state_e          state;
  fetch_state_e          state_next;
  logic [PC_WIDTH-1:0]   pc;
  logic [PC_WIDTH-1:0]   pc_next;
  logic                  valid_next;
  logic                  error_next;
  logic                  capture;

  assign memory_request = (state == FETCH_STATE_REQUEST);
  assign memory_address = pc;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    valid_next = instruction_valid;
    error_next = fetch_error;
    capture    = 1'b0;

    if (redirect_valid && state != FETCH_STATE_ERROR) begin
      // A redirect always withdraws whatever decode was being offered.
      valid_next = 1'b0;
      if (!is_word_aligned(redirect_target)) begin
        error_next = 1'b1;
        state_next = FETCH_STATE_ERROR;
      end else begin
        pc_next = redirect_target;
        case (state)
          FETCH_STATE_REQUEST:
            state_next = memory_ready ? FETCH_STATE_DISCARD : FETCH_STATE_REQUEST;
          FETCH_STATE_WAIT, FETCH_STATE_DISCARD:
            state_next = memory_response_valid ? FETCH_STATE_REQUEST : FETCH_STATE_DISCARD;
          default:
            state_next = FETCH_STATE_REQUEST;
        endcase
      end
    end else begin
      case (state)
        FETCH_STATE_REQUEST: begin
          if (memory_ready) state_next = FETCH_STATE_WAIT;
        end
        FETCH_STATE_WAIT: begin
          if (memory_response_valid) begin
            capture    = 1'b1;
            valid_next = 1'b1;
            state_next = FETCH_STATE_HOLD;
          end
        end
        FETCH_STATE_HOLD: begin
          if (decode_ready) begin
            valid_next = 1'b0;
            pc_next    = pc + 32'd4;
            state_next = FETCH_STATE_REQUEST;
          end
        end
        FETCH_STATE_DISCARD: begin
          if (memory_response_valid) state_next = FETCH_STATE_REQUEST;
        end
        default: begin
          valid_next = 1'b0;
          state_next = FETCH_STATE_ERROR;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH_STATE_REQUEST;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc                <= RESET_VECTOR;
      instruction_valid <= 1'b0;
      instruction       <= '0;
      instruction_pc    <= '0;
      fetch_error       <= 1'b0;
    end else begin
      pc                <= pc_next;
      instruction_valid <= valid_next;
      fetch_error       <= error_next;
      // The output slot only moves on capture, so it holds while decode stalls.
      if (capture) begin
        instruction    <= memory_response_data;
        instruction_pc <= pc;
      end
    end
  end

endmodule
